// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-digit BCD down-counter with load, start/pause
// control, internal prescaler and terminal-count detection.
//
// Parameters:
//   DIGITS    number of BCD digits (count width = 4*DIGITS)
//   TICK_DIV  clk cycles per decrement (>= 1)
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   load        load clamped load_value, go IDLE (aborts a countdown)
//   load_value  BCD preset, digit 0 in [3:0]; digits > 9 clamp to 9
//   start       begin/resume counting (IDLE/PAUSE with nonzero count)
//   pause       suspend counting (wins over start while in RUN)
//   count       registered BCD value
//   running     registered, high while in RUN
//   zero        registered, high when count == 0
//   done        one-cycle pulse on the edge where the count reaches 0
// Optional feature (macro BCD_COUNTDOWN_AUTO_RELOAD_EN):
//   keeps the last loaded value and restarts from it after reaching 0
//   instead of stopping; a zero reload value still ends in DONE.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  zero,
  output logic                  done
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [CW-1:0] clamped;
  logic [CW-1:0] dec_value;
  logic          dec_zero;
  logic          borrow;
  logic [3:0]    digit;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic [CW-1:0] reload;
`endif

  // Clamp each incoming digit to 9 so the count is always valid BCD.
  always_comb begin
    clamped = load_value;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) clamped[4*i +: 4] = 4'd9;
    end
  end

  // Ripple-borrow BCD decrement: a 0 digit becomes 9 and borrows upward.
  always_comb begin
    dec_value = count;
    borrow    = 1'b1;
    digit     = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (borrow) begin
        if (digit == 4'd0) begin
          dec_value[4*i +: 4] = 4'd9;
        end else begin
          dec_value[4*i +: 4] = digit - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    dec_zero = (dec_value == '0);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      presc   <= '0;
      count   <= '0;
      running <= 1'b0;
      zero    <= 1'b1;
      done    <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
      reload  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (load) begin
        state   <= ST_IDLE;
        presc   <= '0;
        count   <= clamped;
        running <= 1'b0;
        zero    <= (clamped == '0);
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        reload  <= clamped;
`endif
      end else begin
        case (state)
          ST_IDLE, ST_PAUSE: begin
            // In PAUSE a simultaneous pause is ignored; start resumes.
            if (start && !zero) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (pause) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              if (zero) begin
                // Only reachable after an auto-reload terminal count.
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                count <= reload;
                zero  <= (reload == '0);
`endif
              end else begin
                count <= dec_value;
                zero  <= dec_zero;
                if (dec_zero) begin
                  done <= 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                  if (reload == '0) begin
                    state   <= ST_DONE;
                    running <= 1'b0;
                  end
`else
                  state   <= ST_DONE;
                  running <= 1'b0;
`endif
                end
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: begin
            // ST_DONE: terminal until reset or load.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: three instances share stimulus
// (2 digits/TICK_DIV=4, 2 digits/TICK_DIV=1, 3 digits/TICK_DIV=1); each
// scenario checks only the instance it targets.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        reset, load, start, pause;
  logic [11:0] lv;

  logic [7:0]  cnt4, cnt1;
  logic [11:0] cnt3;
  logic        run4, zero4, done4;
  logic        run1, zero1, done1;
  logic        run3, zero3, done3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(4)) u4 (
    .clk(clk), .reset(reset), .load(load), .load_value(lv[7:0]),
    .start(start), .pause(pause), .count(cnt4), .running(run4),
    .zero(zero4), .done(done4));

  bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .load(load), .load_value(lv[7:0]),
    .start(start), .pause(pause), .count(cnt1), .running(run1),
    .zero(zero1), .done(done1));

  bcd_countdown_timer #(.DIGITS(3), .TICK_DIV(1)) u3 (
    .clk(clk), .reset(reset), .load(load), .load_value(lv),
    .start(start), .pause(pause), .count(cnt3), .running(run3),
    .zero(zero3), .done(done3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [11:0] v);
    lv = v; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; lv = '0;
    tick(2);
    reset = 1'b0;

    // Reset state
    check("rst_count", 32'(cnt4), 32'h00);
    check("rst_zero", 32'(zero4), 32'd1);
    check("rst_running", 32'(run4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);

    // Basic countdown at TICK_DIV=4: 0x25 for 4 cycles, then 0x24
    do_load(12'h025);
    check("load_zero", 32'(zero4), 32'd0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      check("hold_count", 32'(cnt4), 32'h25);
      check("hold_running", 32'(run4), 32'd1);
      tick(1);
    end
    check("first_dec", 32'(cnt4), 32'h24);
    check("first_dec_running", 32'(run4), 32'd1);

    // Clamp, and load beats start in the same cycle
    lv = 12'h0AF; load = 1'b1; start = 1'b1;
    tick(1);
    load = 1'b0; start = 1'b0;
    check("clamp_count", 32'(cnt4), 32'h99);
    check("load_start_running", 32'(run4), 32'd0);
    tick(2);
    check("idle_hold", 32'(cnt4), 32'h99);

    // Start with count 0 is ignored
    do_load(12'h000);
    check("load0_zero", 32'(zero4), 32'd1);
    do_start();
    check("start0_running", 32'(run4), 32'd0);
    tick(3);
    check("start0_count", 32'(cnt4), 32'h00);

    // Pause after two RUN cycles (prescaler = 2), hold 10 cycles, resume
    do_load(12'h025);
    do_start();
    tick(2);
    pause = 1'b1;
    tick(1);
    check("pause_running", 32'(run4), 32'd0);
    check("pause_count", 32'(cnt4), 32'h25);
    tick(9);
    pause = 1'b0;
    check("pause_hold", 32'(cnt4), 32'h25);
    do_start();
    check("resume_running", 32'(run4), 32'd1);
    check("resume_count0", 32'(cnt4), 32'h25);
    tick(1);
    check("resume_count1", 32'(cnt4), 32'h25);
    tick(1);
    check("resume_dec", 32'(cnt4), 32'h24);

    // Start+pause in RUN: pause wins; in PAUSE: start wins
    start = 1'b1; pause = 1'b1;
    tick(1);
    check("sp_run_pause", 32'(run4), 32'd0);
    tick(1);
    check("sp_pause_resume", 32'(run4), 32'd1);
    start = 1'b0; pause = 1'b0;

    // Three-digit borrow chain: 0x100 -> 0x099
    do_load(12'h100);
    do_start();
    check("b3_entry", 32'(cnt3), 32'h100);
    tick(1);
    check("b3_borrow", 32'(cnt3), 32'h099);

    // Two-digit borrow at TICK_DIV=1: 0x10 -> 0x09
    do_load(12'h010);
    do_start();
    check("b2_entry", 32'(cnt1), 32'h10);
    tick(1);
    check("b2_borrow", 32'(cnt1), 32'h09);

`ifndef BCD_COUNTDOWN_AUTO_RELOAD_EN
    // Terminal count: 0x03 -> 02 -> 01 -> 00 with a single done pulse
    do_load(12'h003);
    do_start();
    check("term_entry", 32'(cnt1), 32'h03);
    check("term_done_pre", 32'(done1), 32'd0);
    tick(1);
    check("term_c2", 32'(cnt1), 32'h02);
    tick(1);
    check("term_c1", 32'(cnt1), 32'h01);
    check("term_c1_done", 32'(done1), 32'd0);
    tick(1);
    check("term_c0", 32'(cnt1), 32'h00);
    check("term_done", 32'(done1), 32'd1);
    check("term_running", 32'(run1), 32'd0);
    check("term_zero", 32'(zero1), 32'd1);
    tick(1);
    check("term_done_clr", 32'(done1), 32'd0);
    check("term_stay0", 32'(cnt1), 32'h00);
    do_start();
    check("term_start_ign_run", 32'(run1), 32'd0);
    tick(2);
    check("term_start_ign_cnt", 32'(cnt1), 32'h00);
    check("term_start_ign_done", 32'(done1), 32'd0);
`else
    // Auto-reload: 0x02 -> 01 -> 00 (done) -> 02 -> 01
    do_load(12'h002);
    do_start();
    check("ar_entry", 32'(cnt1), 32'h02);
    tick(1);
    check("ar_c1", 32'(cnt1), 32'h01);
    tick(1);
    check("ar_c0", 32'(cnt1), 32'h00);
    check("ar_done", 32'(done1), 32'd1);
    check("ar_running", 32'(run1), 32'd1);
    tick(1);
    check("ar_reload", 32'(cnt1), 32'h02);
    check("ar_done_clr", 32'(done1), 32'd0);
    tick(1);
    check("ar_c1b", 32'(cnt1), 32'h01);
    check("ar_running_b", 32'(run1), 32'd1);
`endif

    // Load during RUN aborts without a done pulse
    do_load(12'h001);
    do_start();
    lv = 12'h005; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("abort_count", 32'(cnt1), 32'h05);
    check("abort_done", 32'(done1), 32'd0);
    check("abort_running", 32'(run1), 32'd0);

    // Reset mid-run at 0x17
    do_load(12'h017);
    do_start();
    tick(2);
    check("pre_rst_count", 32'(cnt4), 32'h17);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_count", 32'(cnt4), 32'h00);
    check("mid_rst_zero", 32'(zero4), 32'd1);
    check("mid_rst_running", 32'(run4), 32'd0);
    check("mid_rst_done", 32'(done4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter with load, start/pause control and terminal-count detection.
- Counterpart of the team's BCD up-counters. It counts the other direction, borrowing digit-to-digit instead of carrying.
- Used for timer/countdown features. The count output drives the same BCD-to-7-segment display path as the up-counters.
- Fully synchronous, single clock domain; an internal prescaler sets the decrement rate.

Parameters:
- DIGITS, 2, number of BCD digits; count width is 4*DIGITS.
- TICK_DIV, 1000, clk cycles per decrement (1000 gives 1 s at a 1 ms clk); must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  when high, load load_value into the count and go to IDLE.
- load_value  input  4*DIGITS  BCD preset value; digit 0 is in bits [3:0].
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- count  output  4*DIGITS  current BCD value, registered.
- running  output  1  high while in RUN.
- zero  output  1  high when count == 0.
- done  output  1  one-cycle pulse when the countdown reaches 0.

Behaviour:
- Reset values: count=0, running=0, done=0, zero=1, prescaler=0, state=IDLE.
- Input priority within a cycle: reset > load > start/pause.
- States:
  - IDLE: loaded, not counting.
  - RUN: prescaler advancing.
  - PAUSE: frozen, prescaler value held.
  - DONE: terminal, count=0.
- load, from any state: each digit of load_value that is >9 is clamped to 9 before storing. prescaler clears to 0 and state goes to IDLE. Asserting load during RUN aborts the countdown with no done pulse.
- start:
  - IDLE or PAUSE with count != 0: go to RUN.
  - IDLE with count == 0: ignored, state stays IDLE.
  - DONE: ignored.
  - RUN: no effect.
- pause in RUN: go to PAUSE. If start and pause are both high in RUN, pause wins. In PAUSE, start resumes and a simultaneous pause is ignored.
- Prescaler in RUN:
  - Increments every cycle.
  - In the cycle where it equals TICK_DIV-1, it wraps to 0 and a decrement occurs. count updates on that same edge.
  - The first decrement therefore comes TICK_DIV cycles after entering RUN from a cleared prescaler.
  - With TICK_DIV=1, count decrements every cycle.
- BCD decrement rule:
  - Digit 0 decrements by 1.
  - A digit at 0 becomes 9 and borrows from the next digit, rippling combinationally within one cycle.
  - Example: 0x100 becomes 0x099.
- Terminal count:
  - The decrement that produces 0 moves the state to DONE and clears running on the same edge.
  - done is high for exactly the first cycle in which count reads 0.
  - count never wraps below 0.
- zero = (count == 0), registered alongside count; it is also high in IDLE after reset or after loading 0.
- running = (state == RUN), registered.
- reset mid-operation: all outputs return to their reset values on the next edge; no done pulse is produced.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- When defined:
  - The last loaded (clamped) value is kept in a reload register, reset value 0.
  - On terminal count, done still pulses for one cycle, but count loads from the reload register and the state stays RUN instead of entering DONE.
  - The prescaler keeps running without a gap.
  - If the reload register is 0, behaviour matches the non-reload case and the block enters DONE.
- When undefined: no reload register exists and the terminal behaviour is as specified in Behaviour.

Test Plan:
- DIGITS=2, TICK_DIV=4: load 0x25, start for one cycle -> count=0x25 for 4 cycles, then 0x24; running=1 throughout.
- Borrow: load 0x10, start, TICK_DIV=1 -> next edge count=0x09; DIGITS=3 with load 0x100 -> 0x099.
- Terminal: TICK_DIV=1, load 0x03, start -> 0x02, 0x01, 0x00; done=1 for exactly the 0x00 cycle; state DONE, running=0; a later start is ignored and count stays 0x00.
- Pause/resume: TICK_DIV=4, pause 2 cycles after start for 10 cycles, then start -> count frozen at 0x25 while paused; first decrement 2 cycles after resume.
- Clamp and priority: load_value 0xAF -> count=0x99; load and start in the same cycle -> IDLE, running=0; start with count 0 -> stays IDLE.
- Reset mid-run at count 0x17 -> next edge count=0, zero=1, running=0, done=0. With BCD_COUNTDOWN_AUTO_RELOAD_EN defined: load 0x02, start, TICK_DIV=1 -> sequence 0x01, 0x00 (done=1), 0x02, 0x01, and the count continues.
